// File: rtl/countdown_seq_pkg.sv
// countdown_seq_pkg: shared state encoding, mode codes and modulus lookup for the countdown sequencer
package countdown_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD, S_END, S_ERROR} state_t;
  localparam logic [3:0] MODE_P0 = 4'b1001;
  localparam logic [3:0] MODE_P1 = 4'b0101;
  localparam logic [3:0] MODE_P2 = 4'b0001;
  function automatic logic [3:0] phase_modulus(input logic [1:0] phase);
    return phase == 2'd0 ? MODE_P0 : phase == 2'd1 ? MODE_P1 : MODE_P2;
  endfunction
endpackage

// File: rtl/countdown_sequencer_stall_watchdog.sv
// stall_watchdog: flags a counter whose sampled value stays unchanged for TIMEOUT_CYCLES active cycles
module stall_watchdog #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Active,
  input  logic [3:0] Count,
  output logic       Stall
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] r_cnt;
  logic [3:0]   r_prev;
  logic         w_same;
  assign w_same = Active && (Count == r_prev);
  assign Stall  = w_same && (r_cnt >= W'(TIMEOUT_CYCLES - 1));
  // Count repeated samples while active; hold everything while inactive so a pause only freezes it
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt  <= '0;
      r_prev <= '0;
    end else if (Active) begin
      r_prev <= Count;
      r_cnt  <= w_same ? (Stall ? r_cnt : r_cnt + 1'b1) : '0;
    end
  end
endmodule

// File: rtl/countdown_sequencer.sv
// countdown_sequencer: steps an external down-counter through 9/5/1 phases and reports progress and faults
module countdown_sequencer
  import countdown_seq_pkg::*;
#(
  parameter bit LOOP           = 1'b1,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Abort,
  input  logic       Pause,
  input  logic [3:0] Count,
  output logic [3:0] Mode,
  output logic       Enable,
  output logic [1:0] Phase,
  output logic       PhaseDone,
  output logic       Busy,
  output logic       Error
);
  state_t     r_state, r_saved, w_next, w_saved;
  logic [1:0] r_phase, w_phase;
  logic [3:0] r_mode, w_m;
  logic       r_enable, r_done, r_busy, r_error;
  logic       w_stall, w_wd_clr;
  assign w_m      = phase_modulus(r_phase);
  assign w_wd_clr = Reset || !(r_state inside {S_LOAD, S_RUN, S_HOLD});
  stall_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .Clk(Clk),
    .Reset(w_wd_clr),
    .Active(r_state inside {S_LOAD, S_RUN}),
    .Count(Count),
    .Stall(w_stall)
  );
  // Next state and next phase; Abort beats Pause, which beats fault detection and normal progress
  always_comb begin
    w_next  = r_state;
    w_saved = r_saved;
    w_phase = r_phase;
    if (Abort) w_next = S_IDLE;
    else begin
      unique case (r_state)
        S_IDLE: if (Start) begin
          w_next  = S_LOAD;
          w_phase = 2'd0;
        end
        S_LOAD: if (Pause) begin
          w_next  = S_HOLD;
          w_saved = S_LOAD;
        end else if (w_stall) w_next = S_ERROR;
        else if (Count == w_m) w_next = S_RUN;
        S_RUN: if (Pause) begin
          w_next  = S_HOLD;
          w_saved = S_RUN;
        end else if (w_stall || Count > w_m) w_next = S_ERROR;
        else if (Count == 4'd0) w_next = S_END;
        S_HOLD: if (!Pause) w_next = Count != 4'd0 ? S_RUN : r_saved == S_LOAD ? S_LOAD : S_END;
        S_END: begin
          w_next  = (r_phase == 2'd2 && !LOOP) ? S_IDLE : S_LOAD;
          w_phase = r_phase == 2'd2 ? (LOOP ? 2'd0 : r_phase) : r_phase + 2'd1;
        end
        S_ERROR: w_next = S_ERROR;
        default: w_next = S_IDLE;
      endcase
    end
  end
  // State register with all outputs registered from the next state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_saved  <= S_LOAD;
      r_phase  <= 2'd0;
      r_mode   <= MODE_P0;
      r_enable <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_saved  <= w_saved;
      r_phase  <= w_phase;
      r_mode   <= phase_modulus(w_phase);
      r_enable <= w_next inside {S_LOAD, S_RUN};
      r_done   <= w_next == S_END;
      r_busy   <= w_next inside {S_LOAD, S_RUN, S_HOLD, S_END};
      r_error  <= w_next == S_ERROR;
    end
  end
  assign Mode      = r_mode;
  assign Enable    = r_enable;
  assign Phase     = r_phase;
  assign PhaseDone = r_done;
  assign Busy      = r_busy;
  assign Error     = r_error;
endmodule

// File: tb/tb_countdown_sequencer.sv
// tb_countdown_sequencer: directed tests of the sequencer against negedge down-counter models
module tb_countdown_sequencer;
  logic clk, rst, start, abort, pause;
  logic m_load, m_freeze;
  logic [3:0] m_val, c0, c1;
  logic [3:0] mode0, mode1;
  logic [1:0] ph0, ph1;
  logic en0, en1, done0, done1, busy0, busy1, err0, err1;
  int checks, errors;

  countdown_sequencer #(.LOOP(1'b0), .TIMEOUT_CYCLES(8)) u0 (
    .Clk(clk), .Reset(rst), .Start(start), .Abort(abort), .Pause(pause), .Count(c0),
    .Mode(mode0), .Enable(en0), .Phase(ph0), .PhaseDone(done0), .Busy(busy0), .Error(err0));
  countdown_sequencer #(.LOOP(1'b1), .TIMEOUT_CYCLES(8)) u1 (
    .Clk(clk), .Reset(rst), .Start(start), .Abort(abort), .Pause(pause), .Count(c1),
    .Mode(mode1), .Enable(en1), .Phase(ph1), .PhaseDone(done1), .Busy(busy1), .Error(err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural counters: load 0->M, then count down, one step per falling edge
  always @(negedge clk) begin
    if (m_load) begin
      c0 <= m_val;
      c1 <= m_val;
    end else begin
      if (en0 && !m_freeze) c0 <= c0 == 4'd0 ? mode0 : c0 - 4'd1;
      if (en1 && !m_freeze) c1 <= c1 == 4'd0 ? mode1 : c1 - 4'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    m_load = 1'b1; m_val = 4'd0; m_freeze = 1'b0;
    tick(); tick();
    rst = 1'b0; m_load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mode1 !== 4'b1001) begin errors++; $display("FAIL reset_mode got %b exp 1001", mode1); end
    checks++; if (en1 !== 1'b0) begin errors++; $display("FAIL reset_enable got %b exp 0", en1); end
    checks++; if (ph1 !== 2'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", ph1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy1); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", err1); end
  endtask

  task automatic test_single_sequence();
    logic [3:0] em;
    logic [1:0] ep;
    do_reset();
    do_start();
    checks++; if (en0 !== 1'b1 || mode0 !== 4'b1001) begin errors++; $display("FAIL seq_start got en=%b mode=%b exp en=1 mode=1001", en0, mode0); end
    for (int k = 1; k <= 21; k++) begin
      tick();
      em = k < 11 ? 4'b1001 : k < 18 ? 4'b0101 : 4'b0001;
      ep = k < 11 ? 2'd0 : k < 18 ? 2'd1 : 2'd2;
      checks++; if (done0 !== (k == 10 || k == 17 || k == 20)) begin errors++; $display("FAIL seq_done k=%0d got %b", k, done0); end
      checks++; if (mode0 !== em || ph0 !== ep) begin errors++; $display("FAIL seq_mode k=%0d got mode=%b ph=%0d exp mode=%b ph=%0d", k, mode0, ph0, em, ep); end
    end
    checks++; if (busy0 !== 1'b0 || en0 !== 1'b0 || c0 !== 4'd0) begin errors++; $display("FAIL seq_idle got busy=%b en=%b count=%0d exp 0 0 0", busy0, en0, c0); end
  endtask

  task automatic test_loop();
    int pulses, kk;
    logic [1:0] ep;
    do_reset();
    do_start();
    pulses = 0;
    for (int k = 1; k <= 42; k++) begin
      tick();
      kk = k % 21;
      ep = kk < 11 ? 2'd0 : kk < 18 ? 2'd1 : 2'd2;
      if (done1 === 1'b1) pulses++;
      checks++; if (done1 !== (kk == 10 || kk == 17 || kk == 20)) begin errors++; $display("FAIL loop_done k=%0d got %b", k, done1); end
      checks++; if (ph1 !== ep) begin errors++; $display("FAIL loop_phase k=%0d got %0d exp %0d", k, ph1, ep); end
    end
    checks++; if (pulses != 6) begin errors++; $display("FAIL loop_pulses got %0d exp 6", pulses); end
  endtask

  task automatic test_pause();
    do_reset();
    do_start();
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++; if (done1 !== (k == 15) || err1 !== 1'b0) begin errors++; $display("FAIL pause_done k=%0d got done=%b err=%b", k, done1, err1); end
      if (k == 4 || k == 8) begin
        checks++; if (en1 !== 1'b0 || busy1 !== 1'b1 || c1 !== 4'd6) begin errors++; $display("FAIL pause_hold k=%0d got en=%b busy=%b count=%0d exp 0 1 6", k, en1, busy1, c1); end
      end
      if (k == 3) pause = 1'b1;
      if (k == 8) pause = 1'b0;
    end
  endtask

  task automatic test_stall();
    do_reset();
    do_start();
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 3) m_freeze = 1'b1;
      if (k == 10) begin
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL stall_early got %b exp 0", err1); end
      end
    end
    checks++; if (err1 !== 1'b1 || en1 !== 1'b0 || c1 !== 4'd7) begin errors++; $display("FAIL stall_error got err=%b en=%b count=%0d exp 1 0 7", err1, en1, c1); end
    tick();
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL stall_sticky got %b exp 1", err1); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (err1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL stall_abort got err=%b busy=%b exp 0 0", err1, busy1); end
    m_freeze = 1'b0; m_load = 1'b1; m_val = 4'd0;
    tick(); tick();
    m_load = 1'b0;
    do_start();
    for (int k = 1; k <= 11; k++) begin
      tick();
      checks++; if (done1 !== (k == 10) || err1 !== 1'b0) begin errors++; $display("FAIL stall_rerun k=%0d got done=%b err=%b", k, done1, err1); end
    end
  endtask

  task automatic test_illegal_and_reset();
    do_reset();
    do_start();
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 13) begin
        checks++; if (err1 !== 1'b0 || ph1 !== 2'd1) begin errors++; $display("FAIL illegal_pre got err=%b ph=%0d exp 0 1", err1, ph1); end
        m_load = 1'b1; m_val = 4'hC;
      end
    end
    m_load = 1'b0;
    checks++; if (err1 !== 1'b1 || en1 !== 1'b0) begin errors++; $display("FAIL illegal_error got err=%b en=%b exp 1 0", err1, en1); end
    abort = 1'b1; m_load = 1'b1; m_val = 4'd0;
    tick(); tick();
    abort = 1'b0; m_load = 1'b0;
    do_start();
    for (int k = 1; k <= 13; k++) tick();
    checks++; if (mode1 !== 4'b0101 || en1 !== 1'b1) begin errors++; $display("FAIL midrun_pre got mode=%b en=%b exp 0101 1", mode1, en1); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (mode1 !== 4'b1001 || en1 !== 1'b0 || ph1 !== 2'd0 || done1 !== 1'b0 || busy1 !== 1'b0 || err1 !== 1'b0)
      begin errors++; $display("FAIL midrun_reset got mode=%b en=%b ph=%0d done=%b busy=%b err=%b", mode1, en1, ph1, done1, busy1, err1); end
  endtask

  task automatic test_start_abort_and_load_pause();
    do_reset();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++; if (busy1 !== 1'b0 || en1 !== 1'b0) begin errors++; $display("FAIL start_abort got busy=%b en=%b exp 0 0", busy1, en1); end
    m_freeze = 1'b1;
    do_start();
    pause = 1'b1;
    tick();
    checks++; if (en1 !== 1'b0 || busy1 !== 1'b1 || c1 !== 4'd0) begin errors++; $display("FAIL load_pause got en=%b busy=%b count=%0d exp 0 1 0", en1, busy1, c1); end
    pause = 1'b0;
    tick();
    m_freeze = 1'b0;
    checks++; if (en1 !== 1'b1) begin errors++; $display("FAIL load_resume got en=%b exp 1", en1); end
    for (int k = 3; k <= 12; k++) begin
      tick();
      if (k == 3) begin
        checks++; if (c1 !== 4'd9) begin errors++; $display("FAIL load_reach got count=%0d exp 9", c1); end
      end
      checks++; if (done1 !== (k == 12) || err1 !== 1'b0) begin errors++; $display("FAIL load_done k=%0d got done=%b err=%b", k, done1, err1); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    m_load = 1'b1; m_val = 4'd0; m_freeze = 1'b0;
    test_reset();
    test_single_sequence();
    test_loop();
    test_pause();
    test_stall();
    test_illegal_and_reset();
    test_start_abort_and_load_pause();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
